// File: rtl/mac_pkg.sv
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared types and constants for the MAC header capture/hash path
//            and the MAC learning table model.
// Contents : MAC_W        address width (48)
//            NUM_PORTS    default switch port count
//            PORT_W       default port tag width
//            DA_LAST      byte offset of the last DA byte in a frame
//            SA_LAST      byte offset of the last SA byte in a frame
//            hdr_state_t  header-parser FSM states
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int MAC_W     = 48;
    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = $clog2(NUM_PORTS);
    localparam int DA_LAST   = 5;
    localparam int SA_LAST   = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DA   = 2'd1,
        SA   = 2'd2,
        BODY = 2'd3
    } hdr_state_t;

endpackage : mac_pkg

`default_nettype wire

// File: rtl/mac_fold_hash.sv
// ============================================================================
// Module   : mac_fold_hash
// Purpose  : Folds a 48-bit MAC address into a pADDR_WIDTH-bit table index by
//            XOR-ing successive pADDR_WIDTH-bit chunks, lowest chunk first.
//            The topmost partial chunk is zero-extended. Combinational.
// Ports    : iaddr  in   48           MAC address
//            ohash  out  pADDR_WIDTH  folded index
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_fold_hash
    import mac_pkg::*;
#(
    parameter int pADDR_WIDTH = 14
) (
    input  logic [MAC_W-1:0]       iaddr,
    output logic [pADDR_WIDTH-1:0] ohash
);

    localparam int NCHUNK = (MAC_W + pADDR_WIDTH - 1) / pADDR_WIDTH;
    localparam int PAD_W  = NCHUNK * pADDR_WIDTH;

    // Zero-extending to a whole number of chunks handles the partial top chunk.
    logic [PAD_W-1:0] w_pad;
    assign w_pad = PAD_W'(iaddr);

    always_comb begin
        ohash = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            ohash = ohash ^ w_pad[i*pADDR_WIDTH +: pADDR_WIDTH];
        end
    end

endmodule : mac_fold_hash

`default_nettype wire

// File: rtl/mac_hdr_hash.sv
// ============================================================================
// Module   : mac_hdr_hash
// Purpose  : Ingress header parser in front of the MAC learning/aging table.
//            Captures DA and SA from the received byte stream, folds each to a
//            table index and reports {port, SA index, DA index} with a
//            one-cycle header pulse and a learn strobe (unicast SA only).
//            Counts runt frames (ending before byte 11) in a saturating counter.
// Ports    : iclk       in   1            clock
//            irst_n     in   1            async active-low reset
//            idata      in   8            frame byte, DA[47:40] first
//            ivalid     in   1            byte valid, always consumed
//            isof       in   1            first byte of frame
//            ieof       in   1            last byte of frame
//            ipnum      in   PW           ingress port, sampled with isof
//            opnum      out  PW           port of last complete header
//            osa        out  pADDR_WIDTH  folded SA index
//            oda        out  pADDR_WIDTH  folded DA index
//            oda_mcast  out  1            DA group bit
//            ohdr_vld   out  1            new header pulse
//            owr_en     out  1            learn strobe
//            orunt_cnt  out  pCNT_WIDTH   saturating runt frame count
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_hdr_hash
    import mac_pkg::*;
#(
    parameter int pNUM_PORTS  = 4,
    parameter int pADDR_WIDTH = 14,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                          iclk,
    input  logic                          irst_n,
    input  logic [7:0]                    idata,
    input  logic                          ivalid,
    input  logic                          isof,
    input  logic                          ieof,
    input  logic [$clog2(pNUM_PORTS)-1:0] ipnum,
    output logic [$clog2(pNUM_PORTS)-1:0] opnum,
    output logic [pADDR_WIDTH-1:0]        osa,
    output logic [pADDR_WIDTH-1:0]        oda,
    output logic                          oda_mcast,
    output logic                          ohdr_vld,
    output logic                          owr_en,
    output logic [pCNT_WIDTH-1:0]         orunt_cnt
);

    localparam int PW = $clog2(pNUM_PORTS);

    hdr_state_t          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MAC_W-1:0]    da_q, da_d;
    // Only SA bytes 6..10 need storing; byte 11 is hashed straight off idata.
    logic [MAC_W-9:0]    sa_q, sa_d;
    logic [PW-1:0]       port_q, port_d;
    logic                hdr_done;
    logic                runt_inc;

    logic [pADDR_WIDTH-1:0] w_sa_hash;
    logic [pADDR_WIDTH-1:0] w_da_hash;

    mac_fold_hash #(.pADDR_WIDTH(pADDR_WIDTH)) u_hash_sa (
        .iaddr ({sa_q, idata}),
        .ohash (w_sa_hash)
    );

    mac_fold_hash #(.pADDR_WIDTH(pADDR_WIDTH)) u_hash_da (
        .iaddr (da_q),
        .ohash (w_da_hash)
    );

    // ------------------------------------------------------------------
    // Next-state logic. isof in any state (re)starts a frame; the previous
    // partial frame is dropped without a strobe or runt count.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        da_d     = da_q;
        sa_d     = sa_q;
        port_d   = port_q;
        hdr_done = 1'b0;
        runt_inc = 1'b0;

        if (ivalid) begin
            if (isof) begin
                da_d   = {da_q[MAC_W-9:0], idata};
                port_d = ipnum;
                if (ieof) begin
                    runt_inc = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = 4'd0;
                end else begin
                    state_d  = DA;
                    cnt_d    = 4'd1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        // stray byte outside a frame: ignored
                    end
                    DA: begin
                        da_d  = {da_q[MAC_W-9:0], idata};
                        cnt_d = cnt_q + 4'd1;
                        if (ieof) begin
                            runt_inc = 1'b1;
                            state_d  = IDLE;
                            cnt_d    = 4'd0;
                        end else if (cnt_q == 4'(DA_LAST)) begin
                            state_d = SA;
                        end
                    end
                    SA: begin
                        sa_d = {sa_q[MAC_W-17:0], idata};
                        if (cnt_q == 4'(SA_LAST)) begin
                            // Header complete; a 12-byte frame goes straight to IDLE.
                            hdr_done = 1'b1;
                            cnt_d    = 4'd0;
                            state_d  = ieof ? IDLE : BODY;
                        end else if (ieof) begin
                            runt_inc = 1'b1;
                            state_d  = IDLE;
                            cnt_d    = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    BODY: begin
                        if (ieof) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State, capture and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            da_q      <= '0;
            sa_q      <= '0;
            port_q    <= '0;
            opnum     <= '0;
            osa       <= '0;
            oda       <= '0;
            oda_mcast <= 1'b0;
            ohdr_vld  <= 1'b0;
            owr_en    <= 1'b0;
            orunt_cnt <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            da_q     <= da_d;
            sa_q     <= sa_d;
            port_q   <= port_d;
            ohdr_vld <= hdr_done;
            // SA[40] is the LSB of byte 6, now at sa_q[32]; group SAs are never learned.
            owr_en   <= hdr_done & ~sa_q[32];
            if (hdr_done) begin
                opnum     <= port_q;
                osa       <= w_sa_hash;
                oda       <= w_da_hash;
                oda_mcast <= da_q[40];
            end
            if (runt_inc && !(&orunt_cnt)) begin
                orunt_cnt <= orunt_cnt + 1'b1;
            end
        end
    end

endmodule : mac_hdr_hash

`default_nettype wire
